// File: rtl/wall_probe_arbiter_if.sv
// Signal bundle between the movers/wall lookup (master) and wall_probe_arbiter (slave).
interface wall_probe_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int COORDW = 10
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]        req;
  logic [NREQ*COORDW-1:0] req_x;
  logic [NREQ*COORDW-1:0] req_y;
  logic [NREQ-1:0]        gnt;
  logic                   done;
  logic [IDW-1:0]         done_id;
  logic                   blocked;
  logic [COORDW-1:0]      probe_x;
  logic [COORDW-1:0]      probe_y;
  logic                   probe_valid;
  logic                   wall_hit;

  modport master (
    output req, req_x, req_y, wall_hit,
    input  gnt, done, done_id, blocked, probe_x, probe_y, probe_valid
  );

  modport slave (
    input  req, req_x, req_y, wall_hit,
    output gnt, done, done_id, blocked, probe_x, probe_y, probe_valid
  );
endinterface

// File: rtl/wall_probe_arbiter.sv
// Round-robin arbiter sharing one maze wall lookup among NREQ movers; each job
// probes the four clamped corners of a sprite box and reports blocked/clear.
module wall_probe_arbiter #(
  parameter int NREQ       = 4,
  parameter int COORDW     = 10,
  parameter int HALF       = 10,
  parameter int XMAX       = 380,
  parameter int YMAX       = 432,
  parameter int LOOKUP_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  wall_probe_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW1 = COORDW + 1;
  localparam logic [LOOKUP_LAT-1:0] PIPE_LAST = LOOKUP_LAT'(1) << (LOOKUP_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  state_t                state_q, state_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]        gnt_id_q, gnt_id_d;
  logic [COORDW-1:0]     x_q, x_d;
  logic [COORDW-1:0]     y_q, y_d;
  logic [1:0]            k_q, k_d;
  logic                  hit_acc_q, hit_acc_d;
  logic [LOOKUP_LAT-1:0] vpipe_q, vpipe_d;
  logic [COORDW-1:0]     probe_x_q, probe_x_d;
  logic [COORDW-1:0]     probe_y_q, probe_y_d;
  logic                  probe_valid_q, probe_valid_d;
  logic                  done_q, done_d;
  logic                  blocked_q, blocked_d;
  logic [IDW-1:0]        done_id_q, done_id_d;

  logic                  grant_en;
  logic [IDW-1:0]        win_id;
  logic [COORDW-1:0]     req_x_arr [NREQ];
  logic [COORDW-1:0]     req_y_arr [NREQ];
  logic [COORDW-1:0]     src_x, src_y;
  logic [COORDW-1:0]     lo_x, hi_x, lo_y, hi_y;
  logic [COORDW-1:0]     next_px, next_py;
  logic [1:0]            k_next;
  logic                  hit_in;

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Corner arithmetic uses one extra bit so the low side cannot wrap below zero.
  function automatic logic [COORDW-1:0] corner_lo(input logic [COORDW-1:0] c);
    logic [CW1-1:0] w;
    w = {1'b0, c};
    return (w < CW1'(HALF)) ? '0 : COORDW'(w - CW1'(HALF));
  endfunction

  function automatic logic [COORDW-1:0] corner_hi(input logic [COORDW-1:0] c,
                                                  input logic [CW1-1:0]    lim);
    logic [CW1-1:0] s;
    s = {1'b0, c} + CW1'(HALF);
    return (s > lim) ? COORDW'(lim) : COORDW'(s);
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_x_arr[i] = bus.req_x[i*COORDW +: COORDW];
      req_y_arr[i] = bus.req_y[i*COORDW +: COORDW];
    end
  end

  // Scan from the far end so the nearest requester after rr_ptr wins last.
  always_comb begin
    grant_en = 1'b0;
    win_id   = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (bus.req[wrap_idx(rr_ptr_q, off)]) begin
        grant_en = 1'b1;
        win_id   = wrap_idx(rr_ptr_q, off);
      end
    end
    grant_en = grant_en && (state_q == IDLE) && !reset;
  end

  always_comb begin
    src_x   = grant_en ? req_x_arr[win_id] : x_q;
    src_y   = grant_en ? req_y_arr[win_id] : y_q;
    k_next  = grant_en ? 2'd0 : k_q + 2'd1;
    lo_x    = corner_lo(src_x);
    hi_x    = corner_hi(src_x, CW1'(XMAX));
    lo_y    = corner_lo(src_y);
    hi_y    = corner_hi(src_y, CW1'(YMAX));
    next_px = k_next[0] ? hi_x : lo_x;
    next_py = k_next[1] ? hi_y : lo_y;
  end

  assign hit_in = vpipe_q[LOOKUP_LAT-1] & bus.wall_hit;

  always_comb begin
    // NOTE: every _d starts from a default so no branch below can infer a latch.
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    gnt_id_d      = gnt_id_q;
    x_d           = x_q;
    y_d           = y_q;
    k_d           = k_q;
    hit_acc_d     = hit_acc_q | hit_in;
    vpipe_d       = LOOKUP_LAT'({vpipe_q, probe_valid_q});
    probe_x_d     = probe_x_q;
    probe_y_d     = probe_y_q;
    probe_valid_d = 1'b0;
    done_d        = 1'b0;
    blocked_d     = 1'b0;
    done_id_d     = '0;

    unique case (state_q)
      IDLE: begin
        if (grant_en) begin
          state_d       = ISSUE;
          rr_ptr_d      = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
          gnt_id_d      = win_id;
          x_d           = src_x;
          y_d           = src_y;
          k_d           = 2'd0;
          hit_acc_d     = 1'b0;
          probe_x_d     = next_px;
          probe_y_d     = next_py;
          probe_valid_d = 1'b1;
        end
      end
      ISSUE: begin
        if (k_q == 2'd3) begin
          state_d = DRAIN;
        end else begin
          k_d           = k_next;
          probe_x_d     = next_px;
          probe_y_d     = next_py;
          probe_valid_d = 1'b1;
        end
      end
      DRAIN: begin
        // Only the fourth probe's slot is left, and its result is on wall_hit now.
        if (vpipe_q == PIPE_LAST) begin
          state_d   = RESP;
          done_d    = 1'b1;
          blocked_d = hit_acc_d;
          done_id_d = gnt_id_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: all state, including the probe pipeline, is cleared so an aborted job leaves nothing in flight.
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      gnt_id_q      <= '0;
      x_q           <= '0;
      y_q           <= '0;
      k_q           <= '0;
      hit_acc_q     <= 1'b0;
      vpipe_q       <= '0;
      probe_x_q     <= '0;
      probe_y_q     <= '0;
      probe_valid_q <= 1'b0;
      done_q        <= 1'b0;
      blocked_q     <= 1'b0;
      done_id_q     <= '0;
    end else begin
      // NOTE: non-blocking so every flop captures the pre-edge _d values together.
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      gnt_id_q      <= gnt_id_d;
      x_q           <= x_d;
      y_q           <= y_d;
      k_q           <= k_d;
      hit_acc_q     <= hit_acc_d;
      vpipe_q       <= vpipe_d;
      probe_x_q     <= probe_x_d;
      probe_y_q     <= probe_y_d;
      probe_valid_q <= probe_valid_d;
      done_q        <= done_d;
      blocked_q     <= blocked_d;
      done_id_q     <= done_id_d;
    end
  end

  assign bus.gnt         = grant_en ? (NREQ'(1) << win_id) : '0;
  assign bus.done        = done_q;
  assign bus.done_id     = done_id_q;
  assign bus.blocked     = blocked_q;
  assign bus.probe_x     = probe_x_q;
  assign bus.probe_y     = probe_y_q;
  assign bus.probe_valid = probe_valid_q;

endmodule
